// File: rtl/registrador_universal.sv
// registrador_universal
//
// Multi-mode WIDTH-bit datapath register. When entrada is high, each rising clock edge applies
// one of eight operations selected by modo: hold, parallel load, shift left/right (serial_in
// fills the vacated bit), rotate left/right, count up, or count down. A registered carry flag
// holds the bit shifted/rotated out, the count-up wrap or the count-down borrow. A
// combinational zero flag reports q == 0.
//
// Parameters:
//   WIDTH        data width in bits, 2..32
//   RESET_VALUE  value forced into q while rst is high
//
// Ports:
//   clk        input   1      rising-edge clock
//   rst        input   1      asynchronous, active-high reset (q=RESET_VALUE, carry=0)
//   entrada    input   1      operation enable; low forces hold
//   modo       input   3      operation select
//   d          input   WIDTH  parallel load data
//   serial_in  input   1      bit shifted in by the shift modes
//   q          output  WIDTH  register contents
//   carry      output  1      registered carry / borrow / shifted-out bit
//   zero       output  1      combinational, high when q == 0

module registrador_universal #(
    parameter int unsigned      WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             entrada,
    input  logic [2:0]       modo,
    input  logic [WIDTH-1:0] d,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q,
    output logic             carry,
    output logic             zero
);

    typedef enum logic [2:0] {
        ModoHold       = 3'b000,
        ModoLoad       = 3'b001,
        ModoShiftLeft  = 3'b010,
        ModoShiftRight = 3'b011,
        ModoRotLeft    = 3'b100,
        ModoRotRight   = 3'b101,
        ModoCountUp    = 3'b110,
        ModoCountDown  = 3'b111
    } modo_e;

    localparam logic [WIDTH-1:0] One     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] AllOnes = {WIDTH{1'b1}};

    logic [WIDTH-1:0] q_q, q_d;
    logic             carry_q, carry_d;
    modo_e            modo_sel;

    assign modo_sel = modo_e'(modo);

    // Next-state decode. Every modo encoding is listed, so no input combination leaves the
    // next state undefined; hold and entrada=0 both keep carry sticky.
    always_comb begin
        q_d     = q_q;
        carry_d = carry_q;
        if (entrada) begin
            unique case (modo_sel)
                ModoHold: begin
                    q_d     = q_q;
                    carry_d = carry_q;
                end
                ModoLoad: begin
                    q_d     = d;
                    carry_d = 1'b0;
                end
                ModoShiftLeft: begin
                    q_d     = {q_q[WIDTH-2:0], serial_in};
                    carry_d = q_q[WIDTH-1];
                end
                ModoShiftRight: begin
                    q_d     = {serial_in, q_q[WIDTH-1:1]};
                    carry_d = q_q[0];
                end
                ModoRotLeft: begin
                    q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    carry_d = q_q[WIDTH-1];
                end
                ModoRotRight: begin
                    q_d     = {q_q[0], q_q[WIDTH-1:1]};
                    carry_d = q_q[0];
                end
                ModoCountUp: begin
                    q_d     = q_q + One;
                    carry_d = (q_q == AllOnes);
                end
                ModoCountDown: begin
                    q_d     = q_q - One;
                    carry_d = (q_q == '0);
                end
                default: begin
                    q_d     = q_q;
                    carry_d = carry_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q     <= RESET_VALUE;
            carry_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            carry_q <= carry_d;
        end
    end

    assign q     = q_q;
    assign carry = carry_q;
    assign zero  = (q_q == '0);

endmodule

// File: tb/tb_registrador_universal.sv
// Bench for registrador_universal: a 4-bit instance (reset value 0) and an 8-bit instance
// (reset value A5) run side by side against an arithmetic reference model.

module tb_registrador_universal;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;

    logic       en4, sin4;
    logic [2:0] m4;
    logic [3:0] d4, q4;
    logic       c4, z4;

    logic       en8, sin8;
    logic [2:0] m8;
    logic [7:0] d8, q8;
    logic       c8, z8;

    int unsigned mq4, mc4, mq8, mc8;
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    registrador_universal #(.WIDTH(4), .RESET_VALUE(4'h0)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .entrada  (en4),
        .modo     (m4),
        .d        (d4),
        .serial_in(sin4),
        .q        (q4),
        .carry    (c4),
        .zero     (z4)
    );

    registrador_universal #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .entrada  (en8),
        .modo     (m8),
        .d        (d8),
        .serial_in(sin8),
        .q        (q8),
        .carry    (c8),
        .zero     (z8)
    );

    // Reference behaviour in plain unsigned arithmetic modulo 2^w.
    function automatic void ref_step(input int unsigned w, en, modo, dd, sin, cq, cc,
                                     output int unsigned nq, output int unsigned nc);
        int unsigned mod;
        int unsigned half;
        mod  = 1 << w;
        half = mod / 2;
        nq   = cq;
        nc   = cc;
        if (en != 0) begin
            case (modo)
                1: begin nq = dd;                        nc = 0;               end
                2: begin nq = (cq * 2 + sin) % mod;      nc = cq / half;       end
                3: begin nq = cq / 2 + sin * half;       nc = cq % 2;          end
                4: begin nq = (cq * 2) % mod + cq / half; nc = cq / half;      end
                5: begin nq = cq / 2 + (cq % 2) * half;  nc = cq % 2;          end
                6: begin nq = (cq + 1) % mod;            nc = (cq == mod - 1); end
                7: begin nq = (cq + mod - 1) % mod;      nc = (cq == 0);       end
                default: ;
            endcase
        end
    endfunction

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, " q4"}, q4, mq4);
        check({tag, " carry4"}, c4, mc4);
        check({tag, " zero4"}, z4, (mq4 == 0));
        check({tag, " q8"}, q8, mq8);
        check({tag, " carry8"}, c8, mc8);
        check({tag, " zero8"}, z8, (mq8 == 0));
    endtask

    // One clock edge: advance the model with the inputs present at the edge, then compare.
    task automatic cyc(input string tag);
        int unsigned nq, nc;
        @(posedge clk);
        ref_step(4, en4, m4, d4, sin4, mq4, mc4, nq, nc);
        mq4 = nq;
        mc4 = nc;
        ref_step(8, en8, m8, d8, sin8, mq8, mc8, nq, nc);
        mq8 = nq;
        mc8 = nc;
        #1;
        check_all(tag);
    endtask

    task automatic set4(input logic en, input logic [2:0] m, input logic [3:0] dd,
                        input logic s);
        en4  = en;
        m4   = m;
        d4   = dd;
        sin4 = s;
    endtask

    task automatic set8(input logic en, input logic [2:0] m, input logic [7:0] dd,
                        input logic s);
        en8  = en;
        m8   = m;
        d8   = dd;
        sin8 = s;
    endtask

    initial begin
        set4(1'b0, 3'b000, 4'h0, 1'b0);
        set8(1'b0, 3'b000, 8'h00, 1'b0);
        rst = 1'b0;
        #1 rst = 1'b1;
        #100;
        mq4 = 0;
        mc4 = 0;
        mq8 = 'hA5;
        mc8 = 0;
        check("reset q4", q4, 4'h0);
        check("reset q8", q8, 8'hA5);
        check_all("reset");

        @(negedge clk) rst = 1'b0;

        // Load, back-to-back
        set4(1'b1, 3'b001, 4'b0011, 1'b0);
        cyc("load 0011");
        check("load 0011 const", q4, 4'b0011);
        set4(1'b1, 3'b001, 4'b1011, 1'b0);
        cyc("load 1011");
        set4(1'b1, 3'b001, 4'b1111, 1'b0);
        cyc("load 1111");

        // Enable gating
        set4(1'b1, 3'b001, 4'b0101, 1'b0);
        cyc("load 0101");
        set4(1'b0, 3'b001, 4'b1010, 1'b0);
        repeat (3) cyc("gated");
        check("gated const", q4, 4'b0101);
        set4(1'b1, 3'b001, 4'b1010, 1'b0);
        cyc("ungated");

        // Shift / rotate
        set4(1'b1, 3'b001, 4'b1001, 1'b0);
        cyc("load 1001");
        set4(1'b1, 3'b010, 4'h0, 1'b1);
        cyc("shl");
        check("shl const", q4, 4'b0011);
        set4(1'b1, 3'b011, 4'h0, 1'b0);
        cyc("shr");
        set4(1'b1, 3'b001, 4'b1000, 1'b0);
        cyc("load 1000");
        set4(1'b1, 3'b100, 4'h0, 1'b0);
        cyc("rol");
        check("rol const", q4, 4'b0001);
        set4(1'b1, 3'b101, 4'h0, 1'b0);
        cyc("ror");
        check("ror const", q4, 4'b1000);

        // Count wrap both directions
        set4(1'b1, 3'b001, 4'b1110, 1'b0);
        cyc("load 1110");
        set4(1'b1, 3'b110, 4'h0, 1'b0);
        cyc("up 1111");
        cyc("up wrap");
        check("up wrap carry const", c4, 1'b1);
        set4(1'b1, 3'b111, 4'h0, 1'b0);
        cyc("down borrow");
        check("down borrow const", q4, 4'b1111);
        cyc("down 1110");

        // Async reset mid-count, with a clock edge while held
        set4(1'b1, 3'b001, 4'b0101, 1'b0);
        cyc("load 0101b");
        set4(1'b1, 3'b110, 4'h0, 1'b0);
        cyc("up 0110");
        set8(1'b1, 3'b110, 8'h00, 1'b0);
        #3 rst = 1'b1;
        #1;
        mq4 = 0;
        mc4 = 0;
        mq8 = 'hA5;
        mc8 = 0;
        check_all("async rst");
        @(posedge clk);
        #1;
        check_all("rst held");
        @(negedge clk) rst = 1'b0;
        set8(1'b0, 3'b000, 8'h00, 1'b0);
        cyc("resume count");
        check("resume const", q4, 4'b0001);

        // 8-bit wrap and shift-out
        set8(1'b1, 3'b001, 8'hFF, 1'b0);
        cyc("w8 load ff");
        set8(1'b1, 3'b110, 8'h00, 1'b0);
        cyc("w8 up wrap");
        check("w8 wrap const", q8, 8'h00);
        set8(1'b1, 3'b001, 8'h80, 1'b0);
        cyc("w8 load 80");
        set8(1'b1, 3'b010, 8'h00, 1'b1);
        cyc("w8 shl");
        check("w8 shl const", q8, 8'h01);

        // Random traffic on both instances
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            set4(($urandom_range(3, 0) != 0), 3'($urandom_range(7, 0)),
                 4'($urandom), 1'($urandom));
            set8(($urandom_range(3, 0) != 0), 3'($urandom_range(7, 0)),
                 8'($urandom), 1'($urandom));
            cyc("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
